// File: rtl/tdc_pkg.sv
// Shared types and helpers for the TDC ring-oscillator phase decoder.
package tdc_pkg;

    localparam int N_TAPS  = 16;
    localparam int PHASE_W = 5;

    typedef logic [PHASE_W-1:0] phase_t;
    typedef logic [N_TAPS-1:0]  taps_t;

    // Modular phase difference a - b; the wrap at 2^PHASE_W is intentional.
    function automatic phase_t wrap_sub(input phase_t a, input phase_t b);
        return a - b;
    endfunction

endpackage

// File: rtl/tdc_therm_decode.sv
// Combinational decode of one sampled tap vector: removes the alternating
// inverter polarity, converts the thermometer state to a phase code by
// popcount and flags patterns with other than 0 or 2 circular transitions.
module tdc_therm_decode #(
    parameter int N_TAPS  = 16,
    parameter int PHASE_W = 5
) (
    input  logic [N_TAPS-1:0]  raw,
    output logic [PHASE_W-1:0] code,
    output logic               err
);

    logic [N_TAPS-1:0]  norm;
    logic [N_TAPS-1:0]  norm_rot;
    logic [PHASE_W-1:0] ones;
    logic [PHASE_W-1:0] trans;

    // Normalize odd taps, then count ones and circular transitions.
    always_comb begin
        norm  = '0;
        ones  = '0;
        trans = '0;
        for (int i = 0; i < N_TAPS; i++) begin
            norm[i] = raw[i] ^ i[0];
        end
        // norm_rot[i] holds norm[(i+1) mod N_TAPS].
        norm_rot = {norm[0], norm[N_TAPS-1:1]};
        for (int i = 0; i < N_TAPS; i++) begin
            ones  = ones + PHASE_W'(norm[i]);
            trans = trans + PHASE_W'(norm[i] ^ norm_rot[i]);
        end
    end

    // A leading 1 means the ones run starts at tap 0; otherwise the
    // zeros run does, and the code sits in the upper half of the cycle.
    assign code = norm[0] ? ones : ({PHASE_W{1'b0}} - ones);
    assign err  = !((trans == '0) || (trans == PHASE_W'(2)));

endmodule

// File: rtl/tdc_phase_decoder.sv
// Three-stage TDC phase decoder: capture raw taps, decode to a fine phase
// code, then publish phase, wrapped delta and bubble-error statistics.
module tdc_phase_decoder #(
    parameter int N_TAPS    = 16,
    parameter int PHASE_W   = 5,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [N_TAPS-1:0]    inv_out,
    output logic [PHASE_W-1:0]   phase_code,
    output logic                 phase_valid,
    output logic [PHASE_W-1:0]   phase_delta,
    output logic                 delta_valid,
    output logic                 bubble_err,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    import tdc_pkg::*;

    // Stage registers. v0/v1 qualify raw/code1 as holding a real sample.
    logic [N_TAPS-1:0]  raw;
    logic               v0;
    logic [PHASE_W-1:0] code1;
    logic               err1;
    logic               v1;
    logic [PHASE_W-1:0] dec_code;
    logic               dec_err;

    // Last error-free code and whether it may be used as a delta reference.
    logic [PHASE_W-1:0] prev_code;
    logic               have_prev;

    tdc_therm_decode #(
        .N_TAPS  (N_TAPS),
        .PHASE_W (PHASE_W)
    ) u_decode (
        .raw  (raw),
        .code (dec_code),
        .err  (dec_err)
    );

    // S0: capture the asynchronous taps and the enable alongside them.
    always_ff @(posedge clk) begin
        if (rst) begin
            raw <= '0;
            v0  <= 1'b0;
        end else begin
            raw <= inv_out;
            v0  <= en;
        end
    end

    // S1: register the decoded code and its error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            code1 <= '0;
            err1  <= 1'b0;
            v1    <= 1'b0;
        end else begin
            code1 <= dec_code;
            err1  <= dec_err;
            v1    <= v0;
        end
    end

    // S2: publish outputs; a gap in the sample stream drops the delta reference.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_code  <= '0;
            phase_valid <= 1'b0;
            phase_delta <= '0;
            delta_valid <= 1'b0;
            bubble_err  <= 1'b0;
            err_cnt     <= '0;
            prev_code   <= '0;
            have_prev   <= 1'b0;
        end else if (v1) begin
            phase_valid <= 1'b1;
            bubble_err  <= err1;
            if (err1) begin
                delta_valid <= 1'b0;
                if (err_cnt != '1) begin
                    err_cnt <= err_cnt + 1'b1;
                end
            end else begin
                phase_code  <= code1;
                delta_valid <= have_prev;
                if (have_prev) begin
                    phase_delta <= wrap_sub(code1, prev_code);
                end
                prev_code <= code1;
                have_prev <= 1'b1;
            end
        end else begin
            phase_valid <= 1'b0;
            delta_valid <= 1'b0;
            bubble_err  <= 1'b0;
            have_prev   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_tdc_phase_decoder.sv
// Scoreboard bench for tdc_phase_decoder: directed normalized tap patterns,
// expected responses queued at issue time and checked by a negedge monitor.
module tb_tdc_phase_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [15:0] inv_out;
    logic [4:0]  phase_code;
    logic        phase_valid;
    logic [4:0]  phase_delta;
    logic        delta_valid;
    logic        bubble_err;
    logic [7:0]  err_cnt;

    typedef struct {
        logic [4:0] code;
        logic       dv;
        logic [4:0] delta;
        logic       bub;
        logic [7:0] cnt;
        int         gap;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests  = 0;
    int   n_fail   = 0;
    int   idle_gap = -1;
    int   mon_gap  = 0;

    // ---------------- clock / DUT ----------------
    always #5 clk = ~clk;

    tdc_phase_decoder dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .inv_out     (inv_out),
        .phase_code  (phase_code),
        .phase_valid (phase_valid),
        .phase_delta (phase_delta),
        .delta_valid (delta_valid),
        .bubble_err  (bubble_err),
        .err_cnt     (err_cnt)
    );

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [15:0] to_raw(input logic [15:0] norm);
        return norm ^ 16'hAAAA;
    endfunction

    // Drive one enabled sample (given as the normalized pattern) and queue its response.
    task automatic send(input logic [15:0] norm, input int code, input int dv,
                        input int delta, input int bub, input int cnt);
        exp_t e;
        e.code  = code[4:0];
        e.dv    = dv[0];
        e.delta = delta[4:0];
        e.bub   = bub[0];
        e.cnt   = cnt[7:0];
        e.gap   = idle_gap;
        exp_q.push_back(e);
        idle_gap = 0;
        inv_out  = to_raw(norm);
        en       = 1'b1;
        @(negedge clk);
    endtask

    task automatic idle(input int cycles);
        en      = 1'b0;
        inv_out = 16'h3C5A;
        repeat (cycles) begin
            @(negedge clk);
            if (idle_gap >= 0) idle_gap++;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_code"},  phase_code,  0);
        check({tag, "_pv"},    phase_valid, 0);
        check({tag, "_delta"}, phase_delta, 0);
        check({tag, "_dv"},    delta_valid, 0);
        check({tag, "_bub"},   bubble_err,  0);
        check({tag, "_cnt"},   err_cnt,     0);
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (phase_valid) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_valid: got phase_valid=1 code=%0d expected no sample", phase_code);
                end else begin
                    e = exp_q.pop_front();
                    check("code",   phase_code,  e.code);
                    check("dv",     delta_valid, e.dv);
                    check("bubble", bubble_err,  e.bub);
                    check("errcnt", err_cnt,     e.cnt);
                    if (e.dv) check("delta", phase_delta, e.delta);
                    if (e.gap >= 0) check("valid_gap", mon_gap, e.gap);
                end
                mon_gap = 0;
            end else begin
                check("idle_dv",  delta_valid, 0);
                check("idle_bub", bubble_err,  0);
                mon_gap++;
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        rst     = 1'b1;
        en      = 1'b0;
        inv_out = 16'h0000;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        idle_gap = -1;

        // Normalized all-zero: code 0, delta 0 once a reference exists.
        send(16'h0000, 0, 0, 0, 0, 0);
        send(16'h0000, 0, 1, 0, 0, 0);
        send(16'h0000, 0, 1, 0, 0, 0);

        // Sweep: first 5 ones, all ones, first 3 zeros, back to 5.
        send(16'h001F,  5, 1,  5, 0, 0);
        send(16'hFFFF, 16, 1, 11, 0, 0);
        send(16'hFFF8, 19, 1,  3, 0, 0);
        send(16'h001F,  5, 1, 18, 0, 0);

        // Wrap: 30 then 2.
        send(16'hC000, 30, 1, 25, 0, 0);
        send(16'h0003,  2, 1,  4, 0, 0);

        // Bubble (4 transitions): code holds at 2, counter steps, reference kept.
        send(16'h000D, 2, 0, 0, 1, 1);
        send(16'h000F, 4, 1, 2, 0, 1);

        // One-cycle enable gap between codes 7 and 9.
        send(16'h007F, 7, 1, 3, 0, 1);
        idle(1);
        send(16'h01FF, 9, 0, 0, 0, 1);

        // Bubble storm to saturate the counter.
        for (int k = 1; k <= 300; k++) begin
            send(16'h000D, 9, 0, 0, 1, (1 + k > 255) ? 255 : 1 + k);
        end
        send(16'h01FF, 9, 1, 0, 0, 255);
        idle(3);

        // Reset one cycle after a valid capture: the sample must vanish.
        inv_out = to_raw(16'h0007);
        en      = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        en  = 1'b0;
        @(negedge clk);
        check_all_zero("midrst");
        @(negedge clk);
        rst      = 1'b0;
        idle_gap = -1;
        idle(3);

        // Counter and reference restart from reset.
        send(16'h0000,  0, 0,  0, 0, 0);
        send(16'hFFFF, 16, 1, 16, 0, 0);
        idle(1);

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d samples outstanding expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/tdc_phase_decoder.md
Name: tdc_phase_decoder

Overview:
- Sits directly downstream of the 16-tap ring oscillator in the TDC.
- Samples the free-running tap vector on every rising edge of the reference clock and removes the alternating inverter polarity.
- Converts the bubble-tolerant thermometer state into a 5-bit fine phase code (0..31) and a wrapped phase delta versus the previous sample.
- Flags and counts illegal tap patterns; the downstream DLF/phase-error logic consumes phase_code and phase_delta.

Parameters:
- N_TAPS, 16, number of ring taps sampled (must be a power of 2).
- PHASE_W, 5, phase code width, equal to log2(2*N_TAPS).
- ERR_CNT_W, 8, width of the saturating bubble-error counter.

Ports:
- clk  in  1  reference clock (FREF); sole clock.
- rst  in  1  synchronous, active-high reset.
- en  in  1  decode enable; sampled each clk edge.
- inv_out  in  N_TAPS  raw ring oscillator taps (asynchronous to clk).
- phase_code  out  PHASE_W  decoded fine phase.
- phase_valid  out  1  one-cycle-per-sample qualifier for phase_code.
- phase_delta  out  PHASE_W  (phase_code - previous phase_code) mod 2^PHASE_W.
- delta_valid  out  1  phase_delta is meaningful.
- bubble_err  out  1  current sample was an illegal pattern.
- err_cnt  out  ERR_CNT_W  saturating count of bubble errors since reset.

Behaviour:
- Reset (rst=1 at clk edge):
  - All pipeline registers, phase_code, phase_delta, err_cnt <= 0.
  - phase_valid, delta_valid, bubble_err <= 0.
  - The "have previous" flag is cleared.
  - Reset applied mid-pipeline discards in-flight samples; no valid is issued for them.
- Stage S0 (capture): raw <= inv_out every edge; en is registered alongside as v0.
- Stage S1 (decode):
  - n[i] = raw[i] XOR (i odd).
  - ones = popcount(n), range 0..16.
  - code = n[0] ? ones : (32 - ones) mod 32.
  - Resulting mapping: all-0 -> 0, first k taps 1 -> k, all-1 -> 16, first k taps 0 -> 16+k.
  - Bubble check: count circular transitions t = number of i where n[i] != n[(i+1) mod 16]. t is legal when 0 or 2; any other value sets err.
- Stage S2 (output, registered when v1=1):
  - phase_valid <= 1 and bubble_err <= err.
  - If err=0: phase_code <= code.
  - If err=1: phase_code holds its last good value and err_cnt increments, saturating at all-ones.
  - phase_delta <= code - prev_code (PHASE_W-bit wrap), but only if prev flag is set and err=0; delta_valid follows the same condition.
  - prev_code/prev flag update only on error-free samples.
  - When v1=0: phase_valid, delta_valid, bubble_err <= 0; every other output holds.
- Latency: inv_out sampled at edge N appears on outputs after edge N+2.
- Throughput: one sample per clk while en=1.
- en deassertion clears the prev flag two cycles later, once the last in-flight sample retires. The first valid sample after re-enable therefore has delta_valid=0.
- Wrap: code 31 -> 1 gives delta 2; code 3 -> 3 gives delta 0. The full cycle is ambiguous and is not resolved here.
- Metastability on raw is tolerated by design: the popcount decode errs by at most ±1 code.

Decomposition:
- Package tdc_pkg holds:
  - localparams N_TAPS and PHASE_W;
  - typedef phase_t (logic [PHASE_W-1:0]) and typedef taps_t;
  - function wrap_sub.
- Natural sub-module: tdc_therm_decode, the combinational S1 logic (normalize, popcount, code, transition count, err). The top keeps the registers, prev tracking and counter.

Test Plan:
- Reset then en=1, inv_out=16'hAAAA (normalized all-0) for 3 cycles -> phase_code=0, phase_valid=1 from cycle 3, delta_valid=0 on the first sample and 1 with delta=0 afterwards.
- Sweep normalized patterns: first 5 taps 1 -> code 5; all 1 -> 16; first 3 taps 0 -> 19. Successive samples 19 then 5 -> phase_delta=18.
- Wrap: code 30 followed by code 2 -> phase_delta=4, delta_valid=1.
- Bubble: normalized 1011_0000... (t=4) -> bubble_err=1, phase_code holds previous, err_cnt +1. Force 300 errors -> err_cnt=255 (saturated).
- en dropped for 1 cycle between samples of code 7 and code 9 -> phase_valid gap aligned 2 cycles later, and the next sample has delta_valid=0.
- rst asserted one cycle after a valid capture -> no phase_valid pulse emerges; all outputs are 0 on the following cycle.
